// File: rtl/uart_tx_sequencer.sv
// Buffered UART transmit sequencer: two requesters arbitrate into a FIFO, which is drained by polling tx_idle and writing the send register.
// Define UART_TXSEQ_RR_EN for round-robin arbitration; fixed priority (req0 first) otherwise.
module uart_tx_sequencer #(
    parameter int DEPTH_LOG2    = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk_bus,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [7:0]            req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [7:0]            req1_data,
    output logic                  req1_ready,
    input  logic                  flush,
    output logic [3:0]            uart_address,
    output logic [31:0]           uart_data_o,
    input  logic [31:0]           uart_data_i,
    output logic                  uart_read,
    output logic                  uart_write,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   LEVEL_ONE = (DEPTH_LOG2 + 1)'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_POLL   = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_SETTLE = 2'd3;

    logic [1:0]            state;
    logic [7:0]            settle_cnt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  full;
    logic                  empty;
    logic                  grant0;
    logic                  grant1;
    logic                  push;
    logic                  pop;
    logic [7:0]            push_data;
    logic                  unused_status;

    // Level never exceeds DEPTH, so its top bit alone marks a full FIFO.
    assign full  = level[DEPTH_LOG2];
    assign empty = (level == '0);

`ifdef UART_TXSEQ_RR_EN
    logic rr_pref1;

    assign grant0 = req0_valid & (~req1_valid | ~rr_pref1);
    assign grant1 = req1_valid & (~req0_valid | rr_pref1);

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            rr_pref1 <= 1'b0;
        end else if (push) begin
            rr_pref1 <= req0_ready;
        end
    end
`else
    assign grant0 = req0_valid;
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = grant0 & ~full & ~flush;
    assign req1_ready = grant1 & ~full & ~flush;
    assign push       = req0_ready | req1_ready;
    assign push_data  = req0_ready ? req0_data : req1_data;
    assign pop        = (state == ST_SEND) & ~empty;

    assign unused_status = ^uart_data_i[31:1];

    always_ff @(posedge clk_bus) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // A flush seen in IDLE empties the FIFO, so polling is not started for stale data.
    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty && !flush) begin
                        state <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (uart_data_i[0]) begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    settle_cnt <= 8'(SETTLE_CYCLES);
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt - 8'd1;
                    if (settle_cnt <= 8'd1) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus strobes come from the state register only; address 0x8 is never read.
    always_comb begin
        uart_read    = 1'b0;
        uart_write   = 1'b0;
        uart_address = 4'h0;
        uart_data_o  = 32'h0;
        case (state)
            ST_POLL: begin
                uart_read    = 1'b1;
                uart_address = 4'hC;
            end
            ST_SEND: begin
                uart_write   = 1'b1;
                uart_address = 4'h8;
                uart_data_o  = {24'b0, mem[rd_ptr]};
            end
            default: ;
        endcase
    end

    assign fifo_level = level;
    assign busy       = (state != ST_IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: queue-based model checked every cycle, plus literal scenario checks.
module tb_uart_tx_sequencer;

    localparam int DL2    = 2;
    localparam int DEPTH  = 1 << DL2;
    localparam int SETTLE = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [7:0]   req0_data  = 8'h00;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [7:0]   req1_data  = 8'h00;
    logic         req1_ready;
    logic         flush = 1'b0;
    logic [3:0]   uart_address;
    logic [31:0]  uart_data_o;
    logic [31:0]  uart_data_i;
    logic         status = 1'b1;
    logic         uart_read;
    logic         uart_write;
    logic [DL2:0] fifo_level;
    logic         busy;

    int checks = 0;
    int errors = 0;

    assign uart_data_i = {31'b0, status};

    uart_tx_sequencer #(.DEPTH_LOG2(DL2), .SETTLE_CYCLES(SETTLE)) dut (
        .clk_bus(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .flush(flush), .uart_address(uart_address), .uart_data_o(uart_data_o),
        .uart_data_i(uart_data_i), .uart_read(uart_read), .uart_write(uart_write),
        .fifo_level(fifo_level), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic v1,
                                 input logic [7:0] d1, input logic fl, input logic st);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        flush      = fl;
        status     = st;
    endtask

    // Model: byte queue plus the sequencer's current activity (polling, sending, or settle cycles left).
    logic [7:0] mq[$];
    bit         m_poll, m_send, m_pref1;
    int         m_quiet;
    bit         a0, a1;

    function automatic bit mReady(input int which);
        bit g0, g1;
`ifdef UART_TXSEQ_RR_EN
        g0 = req0_valid && (!req1_valid || !m_pref1);
        g1 = req1_valid && (!req0_valid || m_pref1);
`else
        g0 = req0_valid;
        g1 = req1_valid && !req0_valid;
`endif
        return ((which == 0) ? g0 : g1) && (mq.size() != DEPTH) && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_poll  = 0;
            m_send  = 0;
            m_quiet = 0;
            m_pref1 = 0;
        end else begin
            a0 = mReady(0);
            a1 = mReady(1);
            if (m_send) begin
                void'(mq.pop_front());
                m_send  = 0;
                m_quiet = SETTLE;
            end else if (m_quiet > 0) begin
                m_quiet--;
            end else if (m_poll) begin
                if (flush) m_poll = 0;
                else if (uart_data_i[0]) begin
                    m_poll = 0;
                    m_send = 1;
                end
            end else if (mq.size() != 0 && !flush) begin
                m_poll = 1;
            end
            if (flush) mq.delete();
            else if (a0) begin
                mq.push_back(req0_data);
                m_pref1 = 1;
            end else if (a1) begin
                mq.push_back(req1_data);
                m_pref1 = 0;
            end
        end
    end

    int         cyc = 0;
    int         reads_seen = 0;
    int         last_acc_cyc = 0;
    int         last_wr_cyc = 0;
    logic [7:0] acc_log[$];
    logic [7:0] wr_log[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("req0_ready", {31'b0, req0_ready}, {31'b0, mReady(0)});
            checkOutput("req1_ready", {31'b0, req1_ready}, {31'b0, mReady(1)});
            checkOutput("uart_read", {31'b0, uart_read}, {31'b0, m_poll});
            checkOutput("uart_write", {31'b0, uart_write}, {31'b0, m_send});
            checkOutput("uart_address", {28'b0, uart_address}, m_poll ? 32'hC : (m_send ? 32'h8 : 32'h0));
            checkOutput("uart_data_o", uart_data_o, (m_send && mq.size() > 0) ? {24'b0, mq[0]} : 32'h0);
            checkOutput("fifo_level", {29'b0, fifo_level}, mq.size());
            checkOutput("busy", {31'b0, busy},
                        {31'b0, (m_poll || m_send || m_quiet > 0 || mq.size() != 0)});
            if (req0_valid && req0_ready) begin
                acc_log.push_back(req0_data);
                last_acc_cyc = cyc;
            end else if (req1_valid && req1_ready) begin
                acc_log.push_back(req1_data);
                last_acc_cyc = cyc;
            end
            if (uart_read) reads_seen++;
            if (uart_write) begin
                wr_log.push_back(uart_data_o[7:0]);
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushByte(input logic [7:0] d);
        int n0;
        bit ok;
        n0 = acc_log.size();
        ok = 0;
        req0_valid = 1'b1;
        req0_data  = d;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (acc_log.size() > n0) begin
                ok = 1;
                break;
            end
        end
        #1;
        req0_valid = 1'b0;
        checkOutput("push_accepted", {31'b0, ok}, 32'h1);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    int w0, a0i, r0;
    bit done;

    initial begin
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        @(negedge clk);
        checkOutput("reset_read", {31'b0, uart_read}, 32'h0);
        checkOutput("reset_write", {31'b0, uart_write}, 32'h0);
        checkOutput("reset_addr", {28'b0, uart_address}, 32'h0);
        checkOutput("reset_data", uart_data_o, 32'h0);
        checkOutput("reset_level", {29'b0, fifo_level}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1);

        // Single byte with UART idle: write lands three cycles after acceptance.
        w0 = wr_log.size();
        pushByte(8'h41);
        step(12);
        checkOutput("single_count", wr_log.size() - w0, 32'd1);
        checkOutput("single_byte", {24'b0, wr_log[w0]}, 32'h41);
        checkOutput("single_latency", last_wr_cyc - last_acc_cyc, 32'd3);
        @(negedge clk);
        checkOutput("single_level", {29'b0, fifo_level}, 32'h0);
        checkOutput("single_busy", {31'b0, busy}, 32'h0);
        step(1);

        // Busy UART: nine polls see 0, the tenth sees tx_idle.
        w0 = wr_log.size();
        reads_seen = 0;
        status = 1'b0;
        pushByte(8'h42);
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            if (wr_log.size() > w0) done = 1;
            #1;
            if (reads_seen >= 9) status = 1'b1;
        end
        checkOutput("busy_uart_done", {31'b0, done}, 32'h1);
        step(10);
        checkOutput("busy_uart_reads", reads_seen, 32'd10);
        checkOutput("busy_uart_writes", wr_log.size() - w0, 32'd1);

        // Full FIFO: four bytes with UART stalled, fifth waits for a pop.
        w0 = wr_log.size();
        status = 1'b0;
        for (int i = 0; i < 4; i++) pushByte(8'h10 + 8'(i));
        req0_valid = 1'b1;
        req0_data  = 8'h14;
        step(2);
        @(negedge clk);
        checkOutput("full_level", {29'b0, fifo_level}, 32'd4);
        checkOutput("full_ready0", {31'b0, req0_ready}, 32'h0);
        checkOutput("full_ready1", {31'b0, req1_ready}, 32'h0);
        @(posedge clk);
        #1;
        a0i = acc_log.size();
        status = 1'b1;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(posedge clk);
            if (acc_log.size() > a0i) done = 1;
        end
        #1;
        req0_valid = 1'b0;
        checkOutput("full_fifth_accepted", {31'b0, done}, 32'h1);
        step(40);
        checkOutput("full_write_count", wr_log.size() - w0, 32'd5);
        for (int i = 0; i < 5 && w0 + i < wr_log.size(); i++)
            checkOutput("full_order", {24'b0, wr_log[w0 + i]}, 32'h10 + i);

        // Contention from reset: both requesters hold valid.
        pulseReset();
        a0i = acc_log.size();
        w0 = wr_log.size();
        applyStimulus(1, 8'hAA, 1, 8'h55, 0, 1);
        for (int k = 0; k < 100 && acc_log.size() - a0i < 4; k++) @(posedge clk);
        #1;
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        step(40);
        checkOutput("contend_count", acc_log.size() - a0i, 32'd4);
        checkOutput("contend_writes", wr_log.size() - w0, 32'd4);
        for (int i = 0; i < 4 && a0i + i < acc_log.size() && w0 + i < wr_log.size(); i++) begin
`ifdef UART_TXSEQ_RR_EN
            checkOutput("contend_accept", {24'b0, acc_log[a0i + i]}, (i % 2 == 0) ? 32'hAA : 32'h55);
`else
            checkOutput("contend_accept", {24'b0, acc_log[a0i + i]}, 32'hAA);
`endif
            checkOutput("contend_write", {24'b0, wr_log[w0 + i]}, {24'b0, acc_log[a0i + i]});
        end

        // Flush while polling a stalled UART.
        w0 = wr_log.size();
        status = 1'b0;
        pushByte(8'h21);
        pushByte(8'h22);
        pushByte(8'h23);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_poll_level", {29'b0, fifo_level}, 32'h0);
        checkOutput("flush_poll_read", {31'b0, uart_read}, 32'h0);
        checkOutput("flush_poll_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        status = 1'b1;
        step(20);
        checkOutput("flush_poll_nowrite", wr_log.size() - w0, 32'd0);

        // Flush during SEND, then async reset mid-settle.
        w0 = wr_log.size();
        pushByte(8'h77);
        pushByte(8'h78);
        step(1);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_send_write", {31'b0, uart_write}, 32'h1);
        checkOutput("flush_send_data", uart_data_o, 32'h77);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_read", {31'b0, uart_read}, 32'h0);
        checkOutput("rst_async_write", {31'b0, uart_write}, 32'h0);
        checkOutput("rst_async_addr", {28'b0, uart_address}, 32'h0);
        checkOutput("rst_async_data", uart_data_o, 32'h0);
        checkOutput("rst_async_level", {29'b0, fifo_level}, 32'h0);
        checkOutput("rst_async_busy", {31'b0, busy}, 32'h0);
        #2;
        rst = 1'b0;
        step(15);
        checkOutput("flush_send_count", wr_log.size() - w0, 32'd1);
        if (wr_log.size() > w0) checkOutput("flush_send_byte", {24'b0, wr_log[w0]}, 32'h77);
        @(negedge clk);
        checkOutput("flush_send_level", {29'b0, fifo_level}, 32'h0);
        checkOutput("flush_send_busy", {31'b0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
